// File: rtl/spi_master_if.sv
// Stream and SPI-pin bundle for spi_master. The controller takes the
// master modport; a bench or upstream agent takes the slave modport.
interface spi_master_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       spi_sck;
    logic       spi_csn;
    logic       spi_sdo;
    logic       spi_sdi;

    modport master (
        input  tx_data, tx_valid, tx_last, spi_sdi,
        output tx_ready, rx_data, rx_valid, spi_sck, spi_csn, spi_sdo
    );

    modport slave (
        output tx_data, tx_valid, tx_last, spi_sdi,
        input  tx_ready, rx_data, rx_valid, spi_sck, spi_csn, spi_sdo
    );
endinterface

// File: rtl/spi_master.sv
// Byte-oriented SPI controller, mode 0, MSB first.
// Bytes arrive on a valid/ready stream, each received byte is returned on a
// one-cycle rx_valid strobe, and tx_last closes the chip-select frame.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | csn high, waiting for the first byte of a burst
// SHIFT | 8 sck periods in flight, sample on rise, launch on fall
// WAIT  | byte done, burst still open (csn low), waiting for next byte
// HOLD  | last byte done, csn held low for one half-period
// GAP   | csn high for one half-period before a new burst may start
module spi_master #(
    parameter int TICKS_PER_HALF_SCK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_master_if.master  bus
);

    localparam int HW = $clog2(TICKS_PER_HALF_SCK + 1);
    localparam logic [HW-1:0] HC_TC  = HW'(TICKS_PER_HALF_SCK - 1);
    localparam logic [HW-1:0] HC_ONE = HW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hc_q, hc_d;
    logic [3:0]    bit_q, bit_d;
    logic          sck_q, sck_d;
    logic          csn_q, csn_d;
    logic          sdo_q, sdo_d;
    logic          last_q, last_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;

    logic          ready;
    logic          accept;
    logic          hc_tc;
    logic          byte_done;

    // ready depends only on state, so accept never loops back through tx_valid
    assign accept    = bus.tx_valid && ready;
    assign hc_tc     = (hc_q == HC_TC);
    assign byte_done = (state_q == SHIFT) && hc_tc && sck_q && (bit_q == 4'd7);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WAIT: begin
                if (accept) state_d = SHIFT;
            end
            SHIFT: begin
                if (byte_done) state_d = last_q ? HOLD : WAIT;
            end
            HOLD: begin
                if (hc_tc) state_d = GAP;
            end
            GAP: begin
                if (hc_tc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: timing counters, pins and shift registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hc_q       <= '0;
            bit_q      <= '0;
            sck_q      <= 1'b0;
            csn_q      <= 1'b1;
            sdo_q      <= 1'b0;
            last_q     <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            hc_q       <= hc_d;
            bit_q      <= bit_d;
            sck_q      <= sck_d;
            csn_q      <= csn_d;
            sdo_q      <= sdo_d;
            last_q     <= last_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // Datapath next values; the half-period counter paces SHIFT, HOLD and GAP
    always_comb begin
        hc_d       = hc_q;
        bit_d      = bit_q;
        sck_d      = sck_q;
        csn_d      = csn_q;
        sdo_d      = sdo_q;
        last_d     = last_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        case (state_q)
            IDLE, WAIT: begin
                if (accept) begin
                    csn_d   = 1'b0;
                    sdo_d   = bus.tx_data[7];
                    tx_sh_d = {bus.tx_data[6:0], 1'b0};
                    last_d  = bus.tx_last;
                    bit_d   = '0;
                    hc_d    = '0;
                    sck_d   = 1'b0;
                end
            end
            SHIFT: begin
                if (hc_tc) begin
                    hc_d  = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        rx_sh_d = {rx_sh_q[6:0], bus.spi_sdi};
                    end else if (bit_q == 4'd7) begin
                        // all eight rising edges have been sampled by now
                        rx_data_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        sdo_d   = tx_sh_q[7];
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                    end
                end else begin
                    hc_d = hc_q + HC_ONE;
                end
            end
            HOLD: begin
                if (hc_tc) begin
                    hc_d  = '0;
                    csn_d = 1'b1;
                    sdo_d = 1'b0;
                end else begin
                    hc_d = hc_q + HC_ONE;
                end
            end
            GAP: begin
                if (hc_tc) begin
                    hc_d = '0;
                end else begin
                    hc_d = hc_q + HC_ONE;
                end
            end
            default: begin
                hc_d = '0;
            end
        endcase
    end

    // Outputs: ready from state, pins and receive data straight from registers
    always_comb begin
        ready        = (state_q == IDLE) || (state_q == WAIT);
        bus.tx_ready = ready;
        bus.rx_data  = rx_data_q;
        bus.rx_valid = rx_valid_q;
        bus.spi_sck  = sck_q;
        bus.spi_csn  = csn_q;
        bus.spi_sdo  = sdo_q;
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: one instance with a 4-cycle half-period driven by a
// loopback/byte-slave model, one instance with a 1-cycle half-period in
// loopback. Expected timing comes from the frame arithmetic: accept at
// edge a, sck rises at a+T*(2j+1), rx at a+16T, csn high at a+17T,
// ready again at a+18T, burst pitch 16T+1.
module tb_spi_master;

    localparam int TA = 4;

    logic clk = 1'b0;
    logic rst_n_a = 1'b0;
    logic rst_n_b = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    spi_master_if ifa ();
    spi_master_if ifb ();

    spi_master #(.TICKS_PER_HALF_SCK(TA)) dut_a (.clk(clk), .rst_n(rst_n_a), .bus(ifa));
    spi_master #(.TICKS_PER_HALF_SCK(1))  dut_b (.clk(clk), .rst_n(rst_n_b), .bus(ifb));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // slave side of instance A: loopback or a byte presented MSB first
    logic       loop_a = 1'b1;
    logic       slave_bit_a = 1'b0;
    logic [7:0] slave_byte_a = 8'h00;
    assign ifa.spi_sdi = loop_a ? ifa.spi_sdo : slave_bit_a;
    assign ifb.spi_sdi = ifb.spi_sdo;

    // event log for instance A, sampled on falling clk
    int         rise_t[$];
    logic       rise_sdo[$];
    int         rx_t[$];
    logic [7:0] rx_d[$];
    int         csn_hi_t[$];
    logic       sdo_seen = 1'b0;
    logic       sdo_idle_bad = 1'b0;
    logic       sck_prev = 1'b0;
    logic       csn_prev = 1'b1;

    initial forever begin
        @(negedge clk);
        if (ifa.spi_sck && !sck_prev) begin
            rise_t.push_back(cyc);
            rise_sdo.push_back(ifa.spi_sdo);
        end
        if (ifa.rx_valid) begin
            rx_t.push_back(cyc);
            rx_d.push_back(ifa.rx_data);
        end
        if (ifa.spi_csn && !csn_prev) csn_hi_t.push_back(cyc);
        if (ifa.spi_sdo && !ifa.spi_csn) sdo_seen = 1'b1;
        if (ifa.spi_sdo && ifa.spi_csn) sdo_idle_bad = 1'b1;
        sck_prev = ifa.spi_sck;
        csn_prev = ifa.spi_csn;
        slave_bit_a = slave_byte_a[7 - (rise_t.size() % 8)];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic clr_mon();
        rise_t.delete();
        rise_sdo.delete();
        rx_t.delete();
        rx_d.delete();
        csn_hi_t.delete();
        sdo_seen = 1'b0;
        sdo_idle_bad = 1'b0;
    endtask

    task automatic wait_to(input int n);
        for (int i = 0; i < 5000 && cyc < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] d, input logic last, output int acc);
        ifa.tx_data  = d;
        ifa.tx_last  = last;
        ifa.tx_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (ifa.tx_ready) begin
                acc = cyc + 1;
                break;
            end
        end
        n_tests++;
        if (acc < 0) begin
            n_fail++;
            $display("FAIL push_a timeout: byte %02h not accepted within 2000 cycles", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_b(input logic [7:0] d, input logic last, output int acc);
        ifb.tx_data  = d;
        ifb.tx_last  = last;
        ifb.tx_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (ifb.tx_ready) begin
                acc = cyc + 1;
                break;
            end
        end
        n_tests++;
        if (acc < 0) begin
            n_fail++;
            $display("FAIL push_b timeout: byte %02h not accepted within 2000 cycles", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ifa.tx_valid = 1'b0; ifa.tx_data = 8'h00; ifa.tx_last = 1'b0;
        ifb.tx_valid = 1'b0; ifb.tx_data = 8'h00; ifb.tx_last = 1'b0;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({ifa.spi_csn, ifa.spi_sck, ifa.spi_sdo, ifa.rx_valid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_pins_a: csn/sck/sdo/rxv=%b required 1000",
                     {ifa.spi_csn, ifa.spi_sck, ifa.spi_sdo, ifa.rx_valid});
        end
        n_tests++;
        if (ifa.rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rx_data: got %02h required 00", ifa.rx_data);
        end
        n_tests++;
        if ({ifb.spi_csn, ifb.spi_sck, ifb.spi_sdo, ifb.rx_valid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_pins_b: csn/sck/sdo/rxv=%b required 1000",
                     {ifb.spi_csn, ifb.spi_sck, ifb.spi_sdo, ifb.rx_valid});
        end
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if ({ifa.tx_ready, ifb.tx_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_ready: a/b=%b required 11", {ifa.tx_ready, ifb.tx_ready});
        end
    endtask

    // single-byte frames: 0xA5 looped, 0x00 against a 0x3C slave, then random
    task automatic test_single();
        int         acc;
        logic [7:0] tx, exp_rx;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                tx = 8'hA5; loop_a = 1'b1; slave_byte_a = 8'h00;
            end else if (k == 1) begin
                tx = 8'h00; loop_a = 1'b0; slave_byte_a = 8'h3C;
            end else begin
                tx = 8'($urandom); loop_a = 1'($urandom); slave_byte_a = 8'($urandom);
            end
            exp_rx = loop_a ? tx : slave_byte_a;
            clr_mon();
            push_a(tx, 1'b1, acc);
            ifa.tx_valid = 1'b0;
            ifa.tx_data  = 8'($urandom);
            ifa.tx_last  = 1'($urandom);
            n_tests++;
            if (ifa.spi_csn !== 1'b0) begin
                n_fail++;
                $display("FAIL single_csn_low k=%0d: csn=%b required 0", k, ifa.spi_csn);
            end
            wait_to(acc + 18 * TA - 1);
            n_tests++;
            if (ifa.tx_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL single_ready_gap k=%0d: ready=%b required 0", k, ifa.tx_ready);
            end
            wait_to(acc + 18 * TA);
            n_tests++;
            if (ifa.tx_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL single_ready_back k=%0d: ready=%b required 1", k, ifa.tx_ready);
            end
            wait_to(acc + 18 * TA + 2);
            n_tests++;
            if (rise_t.size() !== 8) begin
                n_fail++;
                $display("FAIL single_rise_count k=%0d: got %0d required 8", k, rise_t.size());
            end else begin
                for (int j = 0; j < 8; j++) begin
                    n_tests++;
                    if (rise_t[j] !== acc + TA * (2 * j + 1) || rise_sdo[j] !== tx[7 - j]) begin
                        n_fail++;
                        $display("FAIL single_rise k=%0d j=%0d: cycle %0d sdo %b required cycle %0d sdo %b",
                                 k, j, rise_t[j] - acc, rise_sdo[j], TA * (2 * j + 1), tx[7 - j]);
                    end
                end
            end
            n_tests++;
            if (rx_t.size() !== 1) begin
                n_fail++;
                $display("FAIL single_rx_count k=%0d: got %0d required 1", k, rx_t.size());
            end else if (rx_t[0] !== acc + 16 * TA || rx_d[0] !== exp_rx) begin
                n_fail++;
                $display("FAIL single_rx k=%0d: cycle %0d data %02h required cycle %0d data %02h",
                         k, rx_t[0] - acc, rx_d[0], 16 * TA, exp_rx);
            end
            n_tests++;
            if (csn_hi_t.size() !== 1 || csn_hi_t[0] !== acc + 17 * TA) begin
                n_fail++;
                $display("FAIL single_csn_rise k=%0d: %0d rises, first at %0d required one at %0d",
                         k, csn_hi_t.size(), (csn_hi_t.size() > 0) ? csn_hi_t[0] - acc : -1, 17 * TA);
            end
            n_tests++;
            if (sdo_seen !== (tx != 8'h00) || sdo_idle_bad !== 1'b0) begin
                n_fail++;
                $display("FAIL single_sdo k=%0d: seen=%b idle_high=%b required seen=%b idle_high=0",
                         k, sdo_seen, sdo_idle_bad, (tx != 8'h00));
            end
        end
        loop_a = 1'b1;
    endtask

    // three-byte bursts with tx_valid held high throughout
    task automatic test_back_to_back();
        int         acc[3];
        logic [7:0] b[3];
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) b[i] = (r == 0) ? 8'(i + 1) : 8'($urandom);
            loop_a = 1'b1;
            clr_mon();
            for (int i = 0; i < 3; i++) push_a(b[i], (i == 2), acc[i]);
            ifa.tx_valid = 1'b0;
            wait_to(acc[0] + 2 * (16 * TA + 1) + 18 * TA + 2);
            for (int i = 1; i < 3; i++) begin
                n_tests++;
                if (acc[i] !== acc[0] + i * (16 * TA + 1)) begin
                    n_fail++;
                    $display("FAIL b2b_accept r=%0d i=%0d: offset %0d required %0d",
                             r, i, acc[i] - acc[0], i * (16 * TA + 1));
                end
            end
            n_tests++;
            if (rise_t.size() !== 24) begin
                n_fail++;
                $display("FAIL b2b_rise_count r=%0d: got %0d required 24", r, rise_t.size());
            end else begin
                for (int j = 0; j < 24; j++) begin
                    n_tests++;
                    if (rise_t[j] !== acc[0] + (j / 8) * (16 * TA + 1) + TA * (2 * (j % 8) + 1)
                        || rise_sdo[j] !== b[j / 8][7 - (j % 8)]) begin
                        n_fail++;
                        $display("FAIL b2b_rise r=%0d j=%0d: cycle %0d sdo %b required cycle %0d sdo %b",
                                 r, j, rise_t[j] - acc[0], rise_sdo[j],
                                 (j / 8) * (16 * TA + 1) + TA * (2 * (j % 8) + 1), b[j / 8][7 - (j % 8)]);
                    end
                end
            end
            n_tests++;
            if (rx_t.size() !== 3) begin
                n_fail++;
                $display("FAIL b2b_rx_count r=%0d: got %0d required 3", r, rx_t.size());
            end else begin
                for (int i = 0; i < 3; i++) begin
                    n_tests++;
                    if (rx_t[i] !== acc[0] + i * (16 * TA + 1) + 16 * TA || rx_d[i] !== b[i]) begin
                        n_fail++;
                        $display("FAIL b2b_rx r=%0d i=%0d: cycle %0d data %02h required cycle %0d data %02h",
                                 r, i, rx_t[i] - acc[0], rx_d[i], i * (16 * TA + 1) + 16 * TA, b[i]);
                    end
                end
            end
            n_tests++;
            if (csn_hi_t.size() !== 1 || csn_hi_t[0] !== acc[0] + 2 * (16 * TA + 1) + 17 * TA) begin
                n_fail++;
                $display("FAIL b2b_csn r=%0d: %0d rises, first at %0d required one at %0d", r,
                         csn_hi_t.size(), (csn_hi_t.size() > 0) ? csn_hi_t[0] - acc[0] : -1,
                         2 * (16 * TA + 1) + 17 * TA);
            end
        end
    endtask

    // burst with a 50-cycle hole between the bytes
    task automatic test_stall();
        int         acc1, acc2, bad;
        logic [7:0] b1, b2;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        loop_a = 1'b1;
        clr_mon();
        push_a(b1, 1'b0, acc1);
        ifa.tx_valid = 1'b0;
        wait_to(acc1 + 16 * TA + 1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (ifa.spi_csn !== 1'b0 || ifa.spi_sck !== 1'b0 || ifa.tx_ready !== 1'b1) bad++;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL stall_idle_pins: %0d of 50 cycles wrong, required 0", bad);
        end
        push_a(b2, 1'b1, acc2);
        ifa.tx_valid = 1'b0;
        wait_to(acc2 + 18 * TA + 2);
        n_tests++;
        if (rx_t.size() !== 2) begin
            n_fail++;
            $display("FAIL stall_rx_count: got %0d required 2", rx_t.size());
        end else if (rx_d[0] !== b1 || rx_d[1] !== b2 || rx_t[1] !== acc2 + 16 * TA) begin
            n_fail++;
            $display("FAIL stall_rx: data %02h %02h second at %0d required %02h %02h at %0d",
                     rx_d[0], rx_d[1], rx_t[1] - acc2, b1, b2, 16 * TA);
        end
        n_tests++;
        if (rise_t.size() !== 16 || csn_hi_t.size() !== 1) begin
            n_fail++;
            $display("FAIL stall_frame: %0d rises %0d csn rises required 16 and 1",
                     rise_t.size(), csn_hi_t.size());
        end else if (csn_hi_t[0] !== acc2 + 17 * TA) begin
            n_fail++;
            $display("FAIL stall_csn: rise at %0d required %0d", csn_hi_t[0] - acc2, 17 * TA);
        end
    endtask

    // reset lands at cycle 30 of a frame, then a fresh 0x5A frame
    task automatic test_reset_mid();
        int acc;
        loop_a = 1'b1;
        clr_mon();
        push_a(8'hC3, 1'b1, acc);
        ifa.tx_valid = 1'b0;
        wait_to(acc + 29);
        rst_n_a = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if ({ifa.spi_csn, ifa.spi_sck, ifa.spi_sdo, ifa.rx_valid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL midreset_pins: csn/sck/sdo/rxv=%b required 1000",
                     {ifa.spi_csn, ifa.spi_sck, ifa.spi_sdo, ifa.rx_valid});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n_a = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (ifa.tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_ready: got %b required 1", ifa.tx_ready);
        end
        repeat (70) @(posedge clk);
        #1;
        n_tests++;
        if (rx_t.size() !== 0) begin
            n_fail++;
            $display("FAIL midreset_partial: %0d rx strobes required 0", rx_t.size());
        end
        clr_mon();
        push_a(8'h5A, 1'b1, acc);
        ifa.tx_valid = 1'b0;
        wait_to(acc + 18 * TA + 2);
        n_tests++;
        if (rx_t.size() !== 1 || rx_d[0] !== 8'h5A || rx_t[0] !== acc + 16 * TA) begin
            n_fail++;
            $display("FAIL midreset_fresh: %0d strobes data %02h at %0d required 1 strobe 5a at %0d",
                     rx_t.size(), (rx_d.size() > 0) ? rx_d[0] : 8'h00,
                     (rx_t.size() > 0) ? rx_t[0] - acc : -1, 16 * TA);
        end
        n_tests++;
        if (csn_hi_t.size() !== 1 || csn_hi_t[0] !== acc + 17 * TA) begin
            n_fail++;
            $display("FAIL midreset_csn: %0d rises required one at %0d", csn_hi_t.size(), 17 * TA);
        end
    endtask

    // one clk per sck half-period, looped back
    task automatic test_t1();
        int         acc, rx_c, csn_c, rises, rx_n;
        logic       prev_sck, ready18;
        logic [7:0] tx, rx_v;
        for (int k = 0; k < 4; k++) begin
            tx = (k == 0) ? 8'hFF : 8'($urandom);
            push_b(tx, 1'b1, acc);
            ifb.tx_valid = 1'b0;
            rx_c = -1; csn_c = -1; rises = 0; rx_n = 0;
            rx_v = 8'h00; ready18 = 1'b0;
            prev_sck = ifb.spi_sck;
            for (int i = 1; i <= 20; i++) begin
                wait_to(acc + i);
                if (ifb.rx_valid) begin
                    rx_c = i; rx_v = ifb.rx_data; rx_n++;
                end
                if (ifb.spi_csn && csn_c < 0) csn_c = i;
                if (ifb.spi_sck && !prev_sck) rises++;
                prev_sck = ifb.spi_sck;
                if (i == 18) ready18 = ifb.tx_ready;
            end
            n_tests++;
            if (rx_n !== 1 || rx_c !== 16 || rx_v !== tx) begin
                n_fail++;
                $display("FAIL t1_rx k=%0d: %0d strobes last at %0d data %02h required 1 at 16 data %02h",
                         k, rx_n, rx_c, rx_v, tx);
            end
            n_tests++;
            if (csn_c !== 17 || rises !== 8 || ready18 !== 1'b1) begin
                n_fail++;
                $display("FAIL t1_frame k=%0d: csn high at %0d rises %0d ready@18 %b required 17 8 1",
                         k, csn_c, rises, ready18);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_t1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Byte-oriented SPI controller (mode 0, MSB first) that drives the SPI slave port of `top` from the other end of the link.
- Used in simulation benches as the stimulus and response engine for the SPI-to-Wishbone path.
- Usable on hardware to drive external SPI peripherals.
- Accepts bytes on a valid/ready stream, returns each received byte on a one-cycle strobe, and frames bursts with `spi_csn`.

Parameters:
- TICKS_PER_HALF_SCK, 4, `clk` cycles per `spi_sck` half-period; legal range is 1 or more.

Ports:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  synchronous reset, active low.
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  `tx_data`/`tx_last` are valid.
- tx_last  input  1  this byte ends the burst; `spi_csn` rises after it.
- tx_ready  output  1  block accepts a byte this cycle.
- rx_data  output  8  byte received during the most recently completed byte.
- rx_valid  output  1  one-cycle strobe; `rx_data` is valid.
- spi_sck  output  1  serial clock; idles low.
- spi_csn  output  1  chip select, active low.
- spi_sdo  output  1  controller-to-slave data.
- spi_sdi  input  1  slave-to-controller data.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset state (on any clock edge with `rst_n`=0, including mid-transfer):
  - state=IDLE, `spi_csn`=1, `spi_sck`=0, `spi_sdo`=0.
  - `rx_valid`=0, `rx_data`=0, all counters cleared.
  - `tx_ready`=1 from the first cycle after reset is released.
  - No partial byte is reported.
- States: IDLE, SHIFT, WAIT, HOLD, GAP.
- Handshake: a byte is accepted when `tx_valid` && `tx_ready` at a rising `clk` edge.
  - `tx_ready` is 1 only in IDLE and WAIT.
  - `tx_data`/`tx_last` are captured on acceptance and may change afterwards.
- IDLE:
  - On accept: `spi_csn`←0, `spi_sdo`←`tx_data[7]`, bit counter←0, half-period counter←0, go to SHIFT.
- SHIFT (T = TICKS_PER_HALF_SCK; cycle 0 = accepting edge):
  - `spi_sck` toggles every T cycles: rising edges at cycles T, 3T, …, 15T; falling edges at 2T, 4T, …, 16T.
  - Rising edge: `spi_sdi` is sampled into the receive shift register (MSB first).
  - Falling edges 1..7: `spi_sdo` ← next transmit bit.
  - Falling edge 8 (cycle 16T): byte complete. `rx_data` ← received byte and `rx_valid`=1 for exactly that one cycle. Then:
    - last byte → HOLD;
    - otherwise → WAIT.
- WAIT:
  - `spi_csn` stays 0, `spi_sck` stays 0, `spi_sdo` holds its value.
  - Stays indefinitely until accept.
  - On accept: same actions as IDLE accept, except `spi_csn` remains 0.
  - First rising `spi_sck` is T cycles after the accept.
- HOLD: T cycles with `spi_csn`=0 and `spi_sck`=0, then `spi_csn`←1 and go to GAP.
- GAP: T cycles with `spi_csn`=1, then go to IDLE.
- Single-byte timing (T=4): accept at cycle 0, `rx_valid` at cycle 64, `spi_csn` high at cycle 68, `tx_ready` high at cycle 72.
- `spi_sdo` is 0 whenever `spi_csn`=1.
- Back-to-back bytes: with `tx_valid` held high, WAIT lasts exactly 1 cycle. Byte pitch = 16T+1 cycles.
- T=1 is legal: `spi_sck` toggles every `clk` cycle.
- `tx_valid` asserted during SHIFT/HOLD/GAP is ignored (`tx_ready`=0); the byte stays pending on the stream.
- Half-period counter width: $clog2(TICKS_PER_HALF_SCK+1). Bit counter: 4 bits.

Test Plan:
- T=4, `spi_sdi` looped to `spi_sdo`, send 0xA5 with `tx_last`=1:
  - 8 `spi_sck` pulses, rising edges at cycles 4,12,…,60;
  - `spi_sdo` bits 1,0,1,0,0,1,0,1;
  - `rx_valid` at cycle 64 with `rx_data`=0xA5;
  - `spi_csn` low over cycles 1–68.
- Slave model returns 0x3C while controller sends 0x00: `rx_data`=0x3C and `spi_sdo` stays 0 throughout.
- Burst 0x01,0x02,0x03 (`tx_last` on 0x03), `tx_valid` held high:
  - `spi_csn` low continuously;
  - `rx_valid` at cycles 64, 129, 194;
  - exactly 24 `spi_sck` rising edges.
- Stall in burst: withhold `tx_valid` for 50 cycles after byte 1 → `spi_csn` stays 0, `spi_sck` stays 0, `tx_ready`=1 for the whole stall; byte 2 proceeds normally afterwards.
- Reset mid-transfer: assert `rst_n`=0 at cycle 30 → next cycle `spi_csn`=1, `spi_sck`=0, `spi_sdo`=0, no `rx_valid`; after release, `tx_ready`=1 and a fresh 0x5A transfers correctly.
- TICKS_PER_HALF_SCK=1: send 0xFF looped back → `rx_data`=0xFF at cycle 16, `spi_csn` high at cycle 17.
